// File: rtl/puf_eval_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : puf_eval_ctrl_if
//  Description : Control, oscillator-bank and result signals of the
//                ring-oscillator PUF evaluation controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface puf_eval_ctrl_if #(
   parameter int CNT_W = 16,
   parameter int NBITS = 8
) ();
   logic             start;
   logic             abort;
   logic [7:0]       challenge;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic             ro_en;
   logic [3:0]       sel_a;
   logic [3:0]       sel_b;
   logic             cnt_clr;
   logic             busy;
   logic             done;
   logic [NBITS-1:0] response;
   logic             tie;
   logic             sat;

   // Requester / oscillator-bank side
   modport master (
      output start, abort, challenge, cnt_a, cnt_b,
      input  ro_en, sel_a, sel_b, cnt_clr, busy, done, response, tie, sat
   );

   // Controller side
   modport slave (
      input  start, abort, challenge, cnt_a, cnt_b,
      output ro_en, sel_a, sel_b, cnt_clr, busy, done, response, tie, sat
   );
endinterface
`default_nettype wire

// File: rtl/puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puf_eval_ctrl
//  Description : Sequences a ring-oscillator PUF: for each response bit it
//                clears the counters, runs both oscillator banks for a fixed
//                window, lets them settle and compares the two counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_eval_ctrl #(
   parameter int CNT_W         = 16,
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 4,
   parameter int NBITS         = 8
) (
   input  wire logic       clk,
   input  wire logic       rst_n,   // active-high despite the name
   puf_eval_ctrl_if.slave  bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_SETTLE  = 3'd3;
   localparam logic [2:0] S_COMPARE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [15:0] c_WIN_LAST    = 16'(WIN_CYCLES - 1);
   localparam logic [15:0] c_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [3:0]  c_K_LAST      = 4'(NBITS - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [15:0]      r_tmr;
   logic [3:0]       r_k;
   logic [3:0]       r_sel_a;
   logic [3:0]       r_sel_b;
   logic [NBITS-1:0] r_resp;
   logic             r_tie;
   logic             r_sat;
   logic             r_ro_en;
   logic             w_accept;
   logic             w_gt;
   logic             w_eq;
   logic             w_full;
   logic             w_cnt_clr;
   logic             w_busy;
   logic             w_done;

   assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
   assign w_gt     = bus.cnt_a > bus.cnt_b;
   assign w_eq     = bus.cnt_a == bus.cnt_b;
   assign w_full   = (bus.cnt_a == {CNT_W{1'b1}}) || (bus.cnt_b == {CNT_W{1'b1}});

   // State register; ro_en is registered from the next state so no input reaches it combinationally
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= S_IDLE;
         r_ro_en <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ro_en <= (w_next == S_RUN);
      end
   end

   // Next-state logic; abort overrides every busy transition
   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE) begin
         if (w_accept) w_next = S_CLEAR;
      end else if (bus.abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_CLEAR:   w_next = S_RUN;
            S_RUN:     if (r_tmr == c_WIN_LAST)    w_next = S_SETTLE;
            S_SETTLE:  if (r_tmr == c_SETTLE_LAST) w_next = S_COMPARE;
            S_COMPARE: w_next = (r_k == c_K_LAST) ? S_DONE : S_CLEAR;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // Output decode from the current state
   always_comb begin
      w_cnt_clr = 1'b0;
      w_busy    = 1'b1;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE:  w_busy    = 1'b0;
         S_CLEAR: w_cnt_clr = 1'b1;
         S_DONE:  w_done    = 1'b1;
         default: ;
      endcase
   end

   // Window/settle timer: restarts on every state change, counts only while timing
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_tmr <= 16'd0;
      end else if (w_next != r_state) begin
         r_tmr <= 16'd0;
      end else if ((r_state == S_RUN) || (r_state == S_SETTLE)) begin
         r_tmr <= r_tmr + 16'd1;
      end
   end

   // Bit index, selects and result capture
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_k     <= 4'd0;
         r_sel_a <= 4'd0;
         r_sel_b <= 4'd0;
         r_resp  <= '0;
         r_tie   <= 1'b0;
         r_sat   <= 1'b0;
      end else if (w_accept) begin
         r_k     <= 4'd0;
         r_sel_a <= bus.challenge[3:0];
         r_sel_b <= bus.challenge[7:4];
         r_resp  <= '0;
         r_tie   <= 1'b0;
         r_sat   <= 1'b0;
      end else if ((r_state == S_COMPARE) && !bus.abort) begin
         for (int i = 0; i < NBITS; i++) begin
            if (r_k == 4'(i)) r_resp[i] <= w_gt;
         end
         if (w_eq)   r_tie <= 1'b1;
         if (w_full) r_sat <= 1'b1;
         // Advancing the selects by one per bit gives (base + k) mod 16
         if (r_k != c_K_LAST) begin
            r_k     <= r_k + 4'd1;
            r_sel_a <= r_sel_a + 4'd1;
            r_sel_b <= r_sel_b + 4'd1;
         end
      end
   end

   assign bus.ro_en    = r_ro_en;
   assign bus.cnt_clr  = w_cnt_clr;
   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.sel_a    = r_sel_a;
   assign bus.sel_b    = r_sel_b;
   assign bus.response = r_resp;
   assign bus.tie      = r_tie;
   assign bus.sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_eval_ctrl
//  Description : Directed self-checking bench for puf_eval_ctrl
//                (WIN_CYCLES=8, SETTLE_CYCLES=2, NBITS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_eval_ctrl;

   localparam int WIN  = 8;
   localparam int SET  = 2;
   localparam int NB   = 4;
   localparam int NCYC = 56;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   puf_eval_ctrl_if #(.CNT_W(16), .NBITS(NB)) bus ();

   puf_eval_ctrl #(
      .CNT_W(16), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET), .NBITS(NB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Oscillator bank model: each select addresses a fixed edge count
   logic [15:0] osc_a [16];
   logic [15:0] osc_b [16];
   assign bus.cnt_a = osc_a[bus.sel_a];
   assign bus.cnt_b = osc_b[bus.sel_b];

   // Per-cycle observations, index 1 = first cycle after the start-accepting edge
   logic       obs_busy [NCYC+1];
   logic       obs_ro   [NCYC+1];
   logic       obs_done [NCYC+1];
   logic       obs_clr  [NCYC+1];
   logic [3:0] obs_sela [NCYC+1];
   logic [3:0] obs_selb [NCYC+1];

   int          ndone, done_cyc, nclr, nrun, badrun;
   logic [15:0] clr_sela, clr_selb;
   logic        sel_unstable;
   logic [17:0] rs_snap;

   task automatic clear_osc();
      for (int i = 0; i < 16; i++) begin
         osc_a[i] = 16'd0;
         osc_b[i] = 16'd0;
      end
   endtask

   // Called just after a negedge: requests a start, then records NCYC cycles
   task automatic run_eval(input logic [7:0] chal, input int start_cyc,
                           input int abort_cyc, input int rst_cyc);
      bus.challenge = chal;
      bus.start     = 1'b1;
      for (int c = 1; c <= NCYC; c++) begin
         @(negedge clk);
         bus.start     = (c == start_cyc);
         bus.abort     = (c == abort_cyc);
         bus.challenge = 8'(c * 37);
         if (c == rst_cyc) begin
            rst_n = 1'b1;
            #1;
            rs_snap = {bus.ro_en, bus.cnt_clr, bus.sel_a, bus.sel_b, bus.busy,
                       bus.done, bus.response, bus.tie, bus.sat};
            #2;
            rst_n = 1'b0;
         end
         obs_busy[c] = bus.busy;
         obs_ro[c]   = bus.ro_en;
         obs_done[c] = bus.done;
         obs_clr[c]  = bus.cnt_clr;
         obs_sela[c] = bus.sel_a;
         obs_selb[c] = bus.sel_b;
      end
      bus.abort = 1'b0;
   endtask

   // Reduce the per-cycle observations to counts
   task automatic analyse();
      int len;
      ndone = 0; done_cyc = 0; nclr = 0; nrun = 0; badrun = 0; len = 0;
      clr_sela = 16'd0; clr_selb = 16'd0; sel_unstable = 1'b0;
      for (int c = 1; c <= NCYC; c++) begin
         if (obs_done[c]) begin
            ndone++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (obs_clr[c]) begin
            nclr++;
            clr_sela = {clr_sela[11:0], obs_sela[c]};
            clr_selb = {clr_selb[11:0], obs_selb[c]};
            for (int j = 1; j <= WIN + SET + 1; j++) begin
               if (c + j <= NCYC && obs_busy[c+j] &&
                   (obs_sela[c+j] != obs_sela[c] || obs_selb[c+j] != obs_selb[c]))
                  sel_unstable = 1'b1;
            end
         end
         if (obs_ro[c]) len++;
         else if (len > 0) begin
            nrun++;
            if (len != WIN) badrun++;
            len = 0;
         end
      end
   endtask

   task automatic nominal_osc();
      clear_osc();
      osc_a[15] = 16'd200; osc_b[3] = 16'd100;   // bit0: A > B
      osc_a[0]  = 16'd50;  osc_b[4] = 16'd60;    // bit1: A < B
      osc_a[1]  = 16'd300; osc_b[5] = 16'd10;    // bit2: A > B
      osc_a[2]  = 16'd5;   osc_b[6] = 16'd7;     // bit3: A < B
   endtask

   task automatic test_reset();
      logic [17:0] snap;
      rst_n = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.challenge = 8'h00;
      clear_osc();
      repeat (2) @(negedge clk);
      snap = {bus.ro_en, bus.cnt_clr, bus.sel_a, bus.sel_b, bus.busy,
              bus.done, bus.response, bus.tie, bus.sat};
      checks++;
      if (snap !== 18'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected %h", snap, 18'd0);
      end
      // start held during reset must not be taken
      bus.start = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_ignores_start: busy=%b expected 0", bus.busy);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_nominal();
      nominal_osc();
      rst_n = 1'b0;               // start offered on the first edge after reset release
      run_eval(8'h3F, 0, 0, 0);
      analyse();
      checks++;
      if (bus.response !== 4'b0101) begin
         failures++; $display("FAIL nominal_response: got %b expected 0101", bus.response);
      end
      checks++;
      if (done_cyc !== 49 || ndone !== 1) begin
         failures++; $display("FAIL nominal_latency: done at %0d count %0d expected 49/1", done_cyc, ndone);
      end
      checks++;
      if (clr_sela !== 16'hF012) begin
         failures++; $display("FAIL nominal_sel_a: got %h expected F012", clr_sela);
      end
      checks++;
      if (clr_selb !== 16'h3456) begin
         failures++; $display("FAIL nominal_sel_b: got %h expected 3456", clr_selb);
      end
      checks++;
      if (sel_unstable !== 1'b0) begin
         failures++; $display("FAIL sel_stable: got %b expected 0", sel_unstable);
      end
      checks++;
      if (nclr !== 4) begin
         failures++; $display("FAIL cnt_clr_pulses: got %0d expected 4", nclr);
      end
      checks++;
      if (nrun !== 4 || badrun !== 0) begin
         failures++; $display("FAIL ro_en_window: runs %0d bad %0d expected 4/0", nrun, badrun);
      end
      checks++;
      if (obs_ro[1] !== 1'b0 || obs_ro[2] !== 1'b1 || obs_ro[10] !== 1'b0) begin
         failures++; $display("FAIL ro_en_phase: c1 %b c2 %b c10 %b expected 0 1 0", obs_ro[1], obs_ro[2], obs_ro[10]);
      end
      checks++;
      if (bus.tie !== 1'b0 || bus.sat !== 1'b0 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL nominal_flags: tie %b sat %b busy %b expected 0 0 0", bus.tie, bus.sat, bus.busy);
      end
   endtask

   task automatic test_tie_sat();
      clear_osc();
      osc_a[0] = 16'd10;    osc_b[0] = 16'd5;      // bit0: 1
      osc_a[1] = 16'd100;   osc_b[1] = 16'd100;    // bit1: tie -> 0
      osc_a[2] = 16'd3;     osc_b[2] = 16'd9;      // bit2: 0
      osc_a[3] = 16'hFFFF;  osc_b[3] = 16'hFFFE;   // bit3: saturated, 1
      run_eval(8'h00, 0, 0, 0);
      analyse();
      checks++;
      if (bus.response !== 4'b1001) begin
         failures++; $display("FAIL tie_sat_response: got %b expected 1001", bus.response);
      end
      checks++;
      if (bus.tie !== 1'b1 || bus.sat !== 1'b1) begin
         failures++; $display("FAIL tie_sat_flags: tie %b sat %b expected 1 1", bus.tie, bus.sat);
      end
      checks++;
      if (done_cyc !== 49) begin
         failures++; $display("FAIL tie_sat_latency: got %0d expected 49", done_cyc);
      end
   endtask

   task automatic test_start_busy();
      nominal_osc();
      run_eval(8'h3F, 15, 0, 0);
      analyse();
      checks++;
      if (ndone !== 1 || done_cyc !== 49) begin
         failures++; $display("FAIL start_busy_done: count %0d at %0d expected 1 at 49", ndone, done_cyc);
      end
      checks++;
      if (bus.response !== 4'b0101) begin
         failures++; $display("FAIL start_busy_response: got %b expected 0101", bus.response);
      end
      checks++;
      if (bus.tie !== 1'b0 || bus.sat !== 1'b0) begin
         failures++; $display("FAIL flags_cleared_on_start: tie %b sat %b expected 0 0", bus.tie, bus.sat);
      end
      checks++;
      if (clr_sela !== 16'hF012) begin
         failures++; $display("FAIL start_busy_sel_a: got %h expected F012", clr_sela);
      end
   endtask

   task automatic test_abort();
      nominal_osc();
      run_eval(8'h3F, 0, 28, 0);  // cycle 28 lies in RUN of bit 2
      analyse();
      checks++;
      if (obs_busy[28] !== 1'b1 || obs_ro[28] !== 1'b1) begin
         failures++; $display("FAIL abort_pre: busy %b ro_en %b expected 1 1", obs_busy[28], obs_ro[28]);
      end
      checks++;
      if (obs_busy[29] !== 1'b0 || obs_ro[29] !== 1'b0) begin
         failures++; $display("FAIL abort_idle: busy %b ro_en %b expected 0 0", obs_busy[29], obs_ro[29]);
      end
      checks++;
      if (ndone !== 0) begin
         failures++; $display("FAIL abort_no_done: got %0d expected 0", ndone);
      end
      checks++;
      if (bus.response !== 4'b0001) begin
         failures++; $display("FAIL abort_partial: got %b expected 0001", bus.response);
      end
   endtask

   task automatic test_reset_mid();
      nominal_osc();
      run_eval(8'h3F, 0, 0, 10);  // cycle 10 is SETTLE of bit 0
      analyse();
      checks++;
      if (rs_snap !== 18'd0) begin
         failures++; $display("FAIL reset_mid_outputs: got %h expected %h", rs_snap, 18'd0);
      end
      checks++;
      if (ndone !== 0 || obs_busy[11] !== 1'b0) begin
         failures++; $display("FAIL reset_mid_abandon: done %0d busy %b expected 0 0", ndone, obs_busy[11]);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_tie_sat();
      test_start_busy();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
